// File: rtl/uart_rx_oversampler.sv
// ============================================================================
// Module   : uart_rx_oversampler
// Purpose  : 16x-oversampling UART receiver with start-bit validation,
//            mid-bit sampling, optional parity and framing status.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_oversampler #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_BRK_WAIT = 3'd5
  } state_t;

  localparam logic [2:0] c_last_bit = 3'(DATA_BITS - 1);
  localparam int         c_shift    = 8 - DATA_BITS;
  localparam logic       c_par_odd  = (PARITY_ODD != 0);
  localparam logic       c_par_en   = (PARITY_EN != 0);

  logic                 r_sync1;
  logic                 r_sync2;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_tick_cnt;
  logic [3:0]           w_tick_nxt;
  logic [2:0]           r_bit_cnt;
  logic [2:0]           w_bit_nxt;
  logic [7:0]           r_shreg;
  logic [7:0]           w_shreg_nxt;
  logic                 r_perr_pend;
  logic                 w_perr_nxt;
  logic                 w_load;
  logic                 w_rxs;
  logic [DATA_BITS-1:0] w_data;
  logic                 w_par_exp;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs     = r_sync2;
  assign w_data    = DATA_BITS'(r_shreg >> c_shift);
  assign w_par_exp = (^w_data) ^ c_par_odd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= 4'd0;
      r_bit_cnt   <= 3'd0;
      r_shreg     <= 8'd0;
      r_perr_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick_cnt  <= w_tick_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shreg     <= w_shreg_nxt;
      r_perr_pend <= w_perr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shreg_nxt = r_shreg;
    w_perr_nxt  = r_perr_pend;
    w_load      = 1'b0;
    if (rx_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            w_state_nxt = S_START;
            w_tick_nxt  = 4'd0;
          end
        end
        S_START: begin
          if (r_tick_cnt == 4'd7) begin
            w_tick_nxt = 4'd0;
            if (!w_rxs) begin
              w_state_nxt = S_DATA;
              w_bit_nxt   = 3'd0;
              w_shreg_nxt = 8'd0;
              w_perr_nxt  = 1'b0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 4'd1;
          end
        end
        S_DATA: begin
          w_tick_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd15) begin
            w_shreg_nxt = {w_rxs, r_shreg[7:1]};
            w_bit_nxt   = r_bit_cnt + 3'd1;
            if (r_bit_cnt == c_last_bit)
              w_state_nxt = c_par_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          w_tick_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd15) begin
            w_perr_nxt  = w_rxs ^ w_par_exp;
            w_state_nxt = S_STOP;
          end
        end
        S_STOP: begin
          w_tick_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd15) begin
            // Leave at mid stop bit to gain half a bit of resync margin.
            w_load      = 1'b1;
            w_state_nxt = w_rxs ? S_IDLE : S_BRK_WAIT;
          end
        end
        S_BRK_WAIT: begin
          if (w_rxs)
            w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_tick_nxt  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_valid <= w_load;
      if (w_load) begin
        rx_data    <= w_data;
        frame_err  <= ~w_rxs;
        parity_err <= r_perr_pend;
      end
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule

`default_nettype wire
